// File: rtl/ws_ctrl.sv
// ws_ctrl: weight-stationary sequencer. Streams weight and activation rows from XMEM into L0
// for each kernel position, and drains OFIFO psum rows into PMEM concurrently.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | issuing COL weight rows for the current kij
// EXEC  | issuing LEN_NIJ activation rows
// FLUSH | one cycle with load/execute/mode all high
// WAIT  | GAP idle cycles before the next kij
// FIN   | waiting for the last PMEM write, then done
module ws_ctrl #(
  parameter int          COL     = 8,
  parameter int          LEN_NIJ = 2,
  parameter int          LEN_KIJ = 9,
  parameter logic [10:0] W_BASE  = 11'h400,
  parameter int          GAP     = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        l0_ready,
  input  logic        ofifo_valid,
  output logic        CEN0_xmem,
  output logic        WEN0_xmem,
  output logic [10:0] A0_xmem,
  output logic        load,
  output logic        execute,
  output logic        mode,
  output logic        CEN_pmem,
  output logic        WEN_pmem,
  output logic [10:0] A_pmem,
  output logic        ofifo_rd,
  output logic [3:0]  kij,
  output logic        busy,
  output logic        done
);

  localparam int TOTAL = LEN_NIJ * LEN_KIJ;
  localparam int TW    = $clog2(((COL > LEN_NIJ) ? COL : LEN_NIJ) + 1);
  localparam int GW    = $clog2(GAP + 1);
  localparam int WW    = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_FLUSH, S_WAIT, S_FIN
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] t, t_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [WW-1:0] wcnt, wcnt_nx, wbase;
  logic [3:0]    kij_nx;
  logic [10:0]   a0_nx, a_pmem_nx;
  logic          cen0_nx, load_nx, execute_nx, mode_nx, busy_nx, done_nx;
  logic          cenp_nx, rd_nx, start_acc;

  always_comb begin
    state_nx   = state;
    t_nx       = t;
    gap_nx     = gap;
    kij_nx     = kij;
    cen0_nx    = 1'b1;
    a0_nx      = A0_xmem;
    load_nx    = load;
    execute_nx = execute;
    mode_nx    = mode;
    busy_nx    = busy;
    done_nx    = 1'b0;
    start_acc  = 1'b0;
    case (state)
      S_IDLE: begin
        load_nx    = 1'b0;
        execute_nx = 1'b0;
        mode_nx    = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nx  = S_LOAD;
          kij_nx    = '0;
          t_nx      = '0;
          busy_nx   = 1'b1;
        end
      end
      S_LOAD: begin
        // A stalled cycle keeps address and array controls, only the enable drops
        if (l0_ready) begin
          cen0_nx    = 1'b0;
          load_nx    = 1'b1;
          execute_nx = 1'b0;
          mode_nx    = 1'b0;
          a0_nx      = W_BASE + 11'(kij * COL) + 11'(t);
          if (t == TW'(COL - 1)) begin
            state_nx = S_EXEC;
            t_nx     = '0;
          end else begin
            t_nx = t + TW'(1);
          end
        end
      end
      S_EXEC: begin
        if (l0_ready) begin
          cen0_nx    = 1'b0;
          load_nx    = 1'b0;
          execute_nx = 1'b1;
          mode_nx    = 1'b0;
          a0_nx      = 11'(t);
          if (t == TW'(LEN_NIJ - 1)) begin
            state_nx = S_FLUSH;
            t_nx     = '0;
          end else begin
            t_nx = t + TW'(1);
          end
        end
      end
      S_FLUSH: begin
        load_nx    = 1'b1;
        execute_nx = 1'b1;
        mode_nx    = 1'b1;
        gap_nx     = GW'(GAP - 1);
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        load_nx    = 1'b0;
        execute_nx = 1'b0;
        mode_nx    = 1'b0;
        if (gap == '0) begin
          if (kij < 4'(LEN_KIJ - 1)) begin
            kij_nx   = kij + 4'd1;
            state_nx = S_LOAD;
          end else begin
            state_nx = S_FIN;
          end
        end else begin
          gap_nx = gap - GW'(1);
        end
      end
      S_FIN: begin
        load_nx    = 1'b0;
        execute_nx = 1'b0;
        mode_nx    = 1'b0;
        if (wcnt == WW'(TOTAL)) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // PMEM drain runs independently of the row sequencing; the count restarts with each run
  always_comb begin
    wbase     = start_acc ? '0 : wcnt;
    wcnt_nx   = wbase;
    rd_nx     = 1'b0;
    cenp_nx   = 1'b1;
    a_pmem_nx = A_pmem;
    if (ofifo_valid && (wbase < WW'(TOTAL))) begin
      rd_nx     = 1'b1;
      cenp_nx   = 1'b0;
      a_pmem_nx = 11'(wbase);
      wcnt_nx   = wbase + WW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      t         <= '0;
      gap       <= '0;
      wcnt      <= '0;
      kij       <= '0;
      CEN0_xmem <= 1'b1;
      WEN0_xmem <= 1'b1;
      A0_xmem   <= '0;
      load      <= 1'b0;
      execute   <= 1'b0;
      mode      <= 1'b0;
      CEN_pmem  <= 1'b1;
      WEN_pmem  <= 1'b1;
      A_pmem    <= '0;
      ofifo_rd  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      t         <= t_nx;
      gap       <= gap_nx;
      wcnt      <= wcnt_nx;
      kij       <= kij_nx;
      CEN0_xmem <= cen0_nx;
      WEN0_xmem <= 1'b1;
      A0_xmem   <= a0_nx;
      load      <= load_nx;
      execute   <= execute_nx;
      mode      <= mode_nx;
      CEN_pmem  <= cenp_nx;
      WEN_pmem  <= cenp_nx;
      A_pmem    <= a_pmem_nx;
      ofifo_rd  <= rd_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_ws_ctrl.sv
// Bench for ws_ctrl: directed run phases with randomized ready/valid/start traffic,
// checked against an arithmetic model of the issue, flush and PMEM write sequences.
`timescale 1ns/1ps
module tb_ws_ctrl;
  localparam int COL   = 8;
  localparam int NIJ   = 2;
  localparam int KIJ   = 9;
  localparam int GAP   = 19;
  localparam int WB    = 'h400;
  localparam int BLK   = COL + NIJ + 1 + GAP;
  localparam int TOTAL = NIJ * KIJ;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, l0_ready = 1'b0, ofifo_valid = 1'b0;
  logic        CEN0_xmem, WEN0_xmem, load, execute, mode, CEN_pmem, WEN_pmem, ofifo_rd, busy, done;
  logic [10:0] A0_xmem, A_pmem;
  logic [3:0]  kij;

  ws_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .l0_ready(l0_ready), .ofifo_valid(ofifo_valid),
    .CEN0_xmem(CEN0_xmem), .WEN0_xmem(WEN0_xmem), .A0_xmem(A0_xmem),
    .load(load), .execute(execute), .mode(mode),
    .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .A_pmem(A_pmem), .ofifo_rd(ofifo_rd),
    .kij(kij), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, flush_cnt = 0, pops = 0, pm_bad = 0;
  int pm_q[$];
  int iss_q[$];

  // Event log sampled 1 ns after each rising edge
  always @(posedge clk) begin
    #1;
    if (!CEN_pmem) begin
      pm_q.push_back(int'(A_pmem));
      if (!(ofifo_rd && !WEN_pmem)) pm_bad++;
    end
    if (ofifo_rd) pops++;
    if (done) done_cnt++;
    if (!CEN0_xmem) iss_q.push_back(int'({load, execute, A0_xmem}));
    if (load && execute && mode) flush_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cen0"},  32'(CEN0_xmem), 1);
    chk({tag, ".wen0"},  32'(WEN0_xmem), 1);
    chk({tag, ".a0"},    32'(A0_xmem),   0);
    chk({tag, ".load"},  32'(load),      0);
    chk({tag, ".exec"},  32'(execute),   0);
    chk({tag, ".mode"},  32'(mode),      0);
    chk({tag, ".cenp"},  32'(CEN_pmem),  1);
    chk({tag, ".wenp"},  32'(WEN_pmem),  1);
    chk({tag, ".ap"},    32'(A_pmem),    0);
    chk({tag, ".rd"},    32'(ofifo_rd),  0);
    chk({tag, ".kij"},   32'(kij),       0);
    chk({tag, ".busy"},  32'(busy),      0);
    chk({tag, ".done"},  32'(done),      0);
  endtask

  logic        ob_cen  [32];
  logic        ob_load [32];
  logic [10:0] ob_a0   [32];

  initial begin
    int   sent, k, p, j0, idx, expv, cyc;
    int   base_iss, base_pm, base_pop, base_done, base_flush;
    logic found;

    // Power-on reset
    repeat (3) step();
    check_reset("por");
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Phase A: l0_ready always high, cycle-exact trace, done gated by the 18th write
    base_pm = pm_q.size(); base_pop = pops; base_done = done_cnt;
    l0_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("a_busy_after_start", 32'(busy), 1);
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      if (!CEN0_xmem) found = 1'b1;
    end
    chk("a_first_issue", 32'(found), 1);
    sent = 0;
    if (found) begin
      for (int j = 0; j < KIJ * BLK; j++) begin
        k = j / BLK;
        p = j % BLK;
        if (p < COL) begin
          chk($sformatf("a_ld_cen[%0d]", j),  32'(CEN0_xmem), 0);
          chk($sformatf("a_ld_a0[%0d]", j),   32'(A0_xmem),   WB + k * COL + p);
          chk($sformatf("a_ld_ctl[%0d]", j),  32'({load, execute, mode}), 3'b100);
          chk($sformatf("a_ld_kij[%0d]", j),  32'(kij), k);
        end else if (p < COL + NIJ) begin
          chk($sformatf("a_ex_cen[%0d]", j),  32'(CEN0_xmem), 0);
          chk($sformatf("a_ex_a0[%0d]", j),   32'(A0_xmem),   p - COL);
          chk($sformatf("a_ex_ctl[%0d]", j),  32'({load, execute}), 2'b01);
          chk($sformatf("a_ex_kij[%0d]", j),  32'(kij), k);
        end else if (p == COL + NIJ) begin
          chk($sformatf("a_fl_cen[%0d]", j),  32'(CEN0_xmem), 1);
          chk($sformatf("a_fl_ctl[%0d]", j),  32'({load, execute, mode}), 3'b111);
          chk($sformatf("a_fl_kij[%0d]", j),  32'(kij), k);
        end else begin
          chk($sformatf("a_gap_cen[%0d]", j), 32'(CEN0_xmem), 1);
          chk($sformatf("a_gap_ctl[%0d]", j), 32'({load, execute, mode}), 3'b000);
        end
        chk($sformatf("a_wen0[%0d]", j), 32'(WEN0_xmem), 1);
        chk($sformatf("a_done[%0d]", j), 32'(done), 0);
        ofifo_valid = (sent < TOTAL - 1) && ($urandom_range(0, 9) == 0);
        if (ofifo_valid) sent++;
        step();
      end
      ofifo_valid = 1'b0;
    end
    while (sent < TOTAL - 1) begin
      ofifo_valid = 1'b1; step(); ofifo_valid = 1'b0; step();
      sent++;
    end
    repeat (5) step();
    chk("a_no_early_done", done_cnt - base_done, 0);
    chk("a_busy_in_fin", 32'(busy), 1);
    chk("a_writes_before_last", pm_q.size() - base_pm, TOTAL - 1);
    ofifo_valid = 1'b1; step(); ofifo_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (done) found = 1'b1;
    end
    chk("a_done_seen", 32'(found), 1);
    step();
    chk("a_done_pulse_len", 32'(done), 0);
    chk("a_busy_after_done", 32'(busy), 0);
    chk("a_done_count", done_cnt - base_done, 1);
    chk("a_pm_n", pm_q.size() - base_pm, TOTAL);
    for (int i = 0; i < TOTAL && base_pm + i < pm_q.size(); i++)
      chk($sformatf("a_pm_addr[%0d]", i), pm_q[base_pm + i], i);
    chk("a_pops", pops - base_pop, TOTAL);

    // Phase B: alternating stalls in LOAD, then random traffic, 20 OFIFO pulses, stray starts
    base_iss = iss_q.size(); base_pm = pm_q.size(); base_pop = pops;
    base_done = done_cnt; base_flush = flush_cnt;
    l0_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      l0_ready = (c % 2 == 0);
      step();
      ob_cen[c] = CEN0_xmem; ob_load[c] = load; ob_a0[c] = A0_xmem;
    end
    j0 = -1;
    for (int c = 0; c < 32; c++)
      if (j0 < 0 && !ob_cen[c]) j0 = c;
    chk("b_first_issue_found", 32'(j0 >= 0 && j0 + 14 < 32), 1);
    if (j0 >= 0 && j0 + 14 < 32) begin
      for (int m = 0; m < 15; m++) begin
        chk($sformatf("b_stall_cen[%0d]", m),  32'(ob_cen[j0 + m]),  (m % 2 == 0) ? 0 : 1);
        chk($sformatf("b_stall_a0[%0d]", m),   32'(ob_a0[j0 + m]),   WB + m / 2);
        chk($sformatf("b_stall_load[%0d]", m), 32'(ob_load[j0 + m]), 1);
      end
    end
    sent = 0;
    cyc = 0;
    while (cyc < 4000 && !(done_cnt > base_done && sent == 20)) begin
      l0_ready    = 1'($urandom_range(0, 1));
      ofifo_valid = (sent < 20) && ($urandom_range(0, 9) == 0 || cyc > 500);
      if (ofifo_valid) sent++;
      start = busy && ($urandom_range(0, 15) == 0);
      step();
      cyc++;
    end
    start = 1'b0; ofifo_valid = 1'b0; l0_ready = 1'b1;
    repeat (3) step();
    chk("b_run_finished", 32'(cyc < 4000), 1);
    chk("b_done_once", done_cnt - base_done, 1);
    chk("b_flushes", flush_cnt - base_flush, KIJ);
    chk("b_iss_n", iss_q.size() - base_iss, KIJ * (COL + NIJ));
    idx = base_iss;
    for (int kk = 0; kk < KIJ; kk++) begin
      for (int i = 0; i < COL + NIJ; i++) begin
        expv = (i < COL) ? ((1 << 12) | (WB + kk * COL + i)) : ((1 << 11) | (i - COL));
        if (idx < iss_q.size()) chk($sformatf("b_iss[%0d][%0d]", kk, i), iss_q[idx], expv);
        idx++;
      end
    end
    chk("b_pm_n", pm_q.size() - base_pm, TOTAL);
    for (int i = 0; i < TOTAL && base_pm + i < pm_q.size(); i++)
      chk($sformatf("b_pm_addr[%0d]", i), pm_q[base_pm + i], i);
    chk("b_pm_last", 32'(A_pmem), TOTAL - 1);
    chk("b_pops", pops - base_pop, TOTAL);

    // Phase C: reset during kij=4 EXEC, then a clean restart
    base_done = done_cnt;
    l0_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      step();
      if (kij == 4'd4 && execute && !CEN0_xmem) found = 1'b1;
    end
    chk("c_reach_k4_exec", 32'(found), 1);
    #3 reset = 1'b1;
    #1;
    check_reset("c_async");
    step(); step();
    check_reset("c_held");
    chk("c_no_done", done_cnt - base_done, 0);
    reset = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      if (!CEN0_xmem) found = 1'b1;
    end
    chk("c_restart_issue", 32'(found), 1);
    chk("c_restart_a0", 32'(A0_xmem), WB);
    chk("c_restart_load", 32'(load), 1);
    chk("c_restart_kij", 32'(kij), 0);

    chk("pm_strobes", pm_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
